// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pkg
//  Description : Shared definitions for the pipelined barrel shifter: op codes,
//                per-level fill modes and the pipeline depth helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  // Operation codes presented on in_op; 101..111 are undefined.
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // What a right-shift level feeds into the vacated top bits.
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_e;

  // Number of register stages needed to cover shw levels, lps at a time.
  function automatic int calc_lat(input int shw, input int lps);
    return (shw + lps - 1) / lps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_stage
//  Description : N_LVL right-shift barrel levels starting at level FIRST_LVL,
//                followed by the stage register with global hold and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 5,
  parameter int FIRST_LVL = 0,
  parameter int N_LVL     = 1,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             advance,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  fill_e            fill_i,
  input  logic             rev_i,
  input  logic             sign_i,
  input  logic             illegal_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output fill_e            fill_o,
  output logic             rev_o,
  output logic             sign_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] lvl_in;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   shamt_q;
  fill_e            fill_q;
  logic             rev_q;
  logic             sign_q;
  logic             illegal_q;
  logic [TAG_W-1:0] tag_q;

  // Barrel levels: level k moves every bit down by 2^k when shamt[k] is set.
  always_comb begin
    data_d = data_i;
    lvl_in = data_i;
    for (int j = 0; j < N_LVL; j++) begin
      lvl_in = data_d;
      if (shamt_i[FIRST_LVL + j]) begin
        for (int b = 0; b < WIDTH; b++) begin
          int step;
          int src;
          step = 1 << (FIRST_LVL + j);
          // Modulo keeps the select in range; it is also the wrap source.
          src  = (b + step) % WIDTH;
          if (b + step < WIDTH) begin
            data_d[b] = lvl_in[src];
          end else begin
            case (fill_i)
              FILL_SIGN: data_d[b] = sign_i;
              FILL_ROT:  data_d[b] = lvl_in[src];
              default:   data_d[b] = 1'b0;
            endcase
          end
        end
      end
    end
  end

  // Stage register: cleared by reset, squashed by flush, frozen on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      shamt_q   <= '0;
      fill_q    <= FILL_ZERO;
      rev_q     <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
      tag_q     <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
    end else if (advance) begin
      valid_q   <= valid_i;
      data_q    <= data_d;
      shamt_q   <= shamt_i;
      fill_q    <= fill_i;
      rev_q     <= rev_i;
      sign_q    <= sign_i;
      illegal_q <= illegal_i;
      tag_q     <= tag_i;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign shamt_o   = shamt_q;
  assign fill_o    = fill_q;
  assign rev_o     = rev_q;
  assign sign_o    = sign_q;
  assign illegal_o = illegal_q;
  assign tag_o     = tag_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_shifter
//  Description : Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with
//                valid/ready handshakes, global stall and synchronous flush.
//                Left ops are bit-reversed in and out so that every barrel
//                level is a right shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 5,
  localparam int SHW             = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int LAT = calc_lat(SHW, LEVELS_PER_STAGE);

  // Index 0 is the decoded entry operation, index s+1 the output of stage s.
  logic             v_w     [LAT+1];
  logic [WIDTH-1:0] data_w  [LAT+1];
  logic [SHW-1:0]   shamt_w [LAT+1];
  fill_e            fill_w  [LAT+1];
  logic             rev_w   [LAT+1];
  logic             sign_w  [LAT+1];
  logic             ill_w   [LAT+1];
  logic [TAG_W-1:0] tag_w   [LAT+1];

  logic             advance_w;
  logic [WIDTH-1:0] in_rev_w;
  logic [WIDTH-1:0] out_rev_w;
  logic             unused_w;

  // Single global stall: the whole pipe moves only when the output slot frees.
  assign advance_w = !v_w[LAT] || out_ready;
  assign in_ready  = advance_w && !flush;

  // Entry decode. Undefined ops get a zero shift so the operand passes through.
  assign v_w[0]     = in_valid;
  assign ill_w[0]   = (in_op > OP_ROR);
  assign rev_w[0]   = (in_op == OP_SLL) || (in_op == OP_ROL);
  assign fill_w[0]  = (in_op == OP_SRA) ? FILL_SIGN :
                      ((in_op == OP_ROL) || (in_op == OP_ROR)) ? FILL_ROT : FILL_ZERO;
  assign sign_w[0]  = in_a[WIDTH-1];
  assign shamt_w[0] = ill_w[0] ? '0 : in_shamt;
  assign tag_w[0]   = in_tag;
  assign data_w[0]  = rev_w[0] ? in_rev_w : in_a;

  for (genvar b = 0; b < WIDTH; b++) begin : g_rev
    assign in_rev_w[b]  = in_a[WIDTH-1-b];
    assign out_rev_w[b] = data_w[LAT][WIDTH-1-b];
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int FIRST = s * LEVELS_PER_STAGE;
    localparam int NL    = ((SHW - FIRST) < LEVELS_PER_STAGE) ? (SHW - FIRST) : LEVELS_PER_STAGE;

    shift_stage #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .FIRST_LVL (FIRST),
      .N_LVL     (NL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .advance   (advance_w),
      .valid_i   (v_w[s]),
      .data_i    (data_w[s]),
      .shamt_i   (shamt_w[s]),
      .fill_i    (fill_w[s]),
      .rev_i     (rev_w[s]),
      .sign_i    (sign_w[s]),
      .illegal_i (ill_w[s]),
      .tag_i     (tag_w[s]),
      .valid_o   (v_w[s+1]),
      .data_o    (data_w[s+1]),
      .shamt_o   (shamt_w[s+1]),
      .fill_o    (fill_w[s+1]),
      .rev_o     (rev_w[s+1]),
      .sign_o    (sign_w[s+1]),
      .illegal_o (ill_w[s+1]),
      .tag_o     (tag_w[s+1])
    );
  end

  // Exit: undo the entry reversal for left ops.
  assign out_valid   = v_w[LAT];
  assign out_r       = rev_w[LAT] ? out_rev_w : data_w[LAT];
  assign out_tag     = tag_w[LAT];
  assign out_illegal = ill_w[LAT];

  // Control fields that are spent once the last level is done.
  assign unused_w = ^{shamt_w[LAT], fill_w[LAT], sign_w[LAT]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipelined_shifter
//  Description : Scoreboard bench for pipelined_shifter at the default
//                configuration plus WIDTH=8/LPS=1 and WIDTH=64/LPS=6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  tag;
    logic        ill;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  logic rst, flush;

  // Default configuration (WIDTH=32, LPS=2, LAT=3)
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_a, out_r;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic [2:0]  in_op;

  // WIDTH=8, LPS=1 (LAT=3)
  logic        s8_valid, s8_ready, s8_ovalid, s8_oill;
  logic [7:0]  s8_a, s8_r;
  logic [2:0]  s8_shamt, s8_op;
  logic [4:0]  s8_tag, s8_otag;

  // WIDTH=64, LPS=6 (LAT=1)
  logic        s64_valid, s64_ready, s64_ovalid, s64_oill;
  logic [63:0] s64_a, s64_r;
  logic [5:0]  s64_shamt;
  logic [2:0]  s64_op;
  logic [4:0]  s64_tag, s64_otag;

  logic sw_ready;

  pipelined_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  pipelined_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(5)) u_dut8 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s8_valid), .in_ready(s8_ready), .in_a(s8_a), .in_shamt(s8_shamt),
    .in_op(s8_op), .in_tag(s8_tag),
    .out_valid(s8_ovalid), .out_ready(sw_ready), .out_r(s8_r),
    .out_tag(s8_otag), .out_illegal(s8_oill)
  );

  pipelined_shifter #(.WIDTH(64), .LEVELS_PER_STAGE(6), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s64_valid), .in_ready(s64_ready), .in_a(s64_a), .in_shamt(s64_shamt),
    .in_op(s64_op), .in_tag(s64_tag),
    .out_valid(s64_ovalid), .out_ready(sw_ready), .out_r(s64_r),
    .out_tag(s64_otag), .out_illegal(s64_oill)
  );

  exp_t q_main[$];
  exp_t q8[$];
  exp_t q64[$];

  int checks = 0;
  int errors = 0;

  // Pending expectations for whatever is currently driven on each input
  logic [63:0] pend_r, pend8_r, pend64_r;
  logic        pend_ill, pend8_ill, pend64_ill, pend_push;
  logic        chk_lat, last_acc;
  logic        bp_en;
  int          bp_i;
  logic        prev_stall;
  logic [31:0] hold_r;
  logic [4:0]  hold_tag;
  logic        hold_ill;

  // Reference model for any width up to 64
  function automatic logic [63:0] ref_model(input int w, input logic [63:0] a_in,
                                            input int sh, input logic [2:0] op,
                                            output logic ill);
    logic [63:0] mask, a, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    ill  = 1'b0;
    case (op)
      3'd0:    r = (a << sh) & mask;
      3'd1:    r = a >> sh;
      3'd2:    r = (a >> sh) | (a[w-1] ? (mask & ~(mask >> sh)) : 64'd0);
      3'd3:    r = ((a << sh) | (a >> (w - sh))) & mask;
      3'd4:    r = ((a >> sh) | (a << (w - sh))) & mask;
      default: begin r = a; ill = 1'b1; end
    endcase
    return r;
  endfunction

  // Per-cycle sampling, scoreboard push/pop and checks for all three DUTs
  task automatic monitor();
    exp_t e;
    last_acc = in_valid && in_ready;
    if (!rst) begin
      if (in_valid && in_ready && pend_push) begin
        e.r = pend_r; e.tag = in_tag; e.ill = pend_ill; e.stamp = pcyc;
        q_main.push_back(e);
      end
      if (prev_stall) begin
        checks++;
        assert (out_valid === 1'b1 && out_r === hold_r && out_tag === hold_tag && out_illegal === hold_ill)
        else begin
          errors++;
          $error("FAIL hold: got v=%b r=%h tag=%0d ill=%b expected v=1 r=%h tag=%0d ill=%b",
                 out_valid, out_r, out_tag, out_illegal, hold_r, hold_tag, hold_ill);
        end
      end
      if (out_valid && !out_ready && !flush) begin
        checks++;
        assert (in_ready === 1'b0)
        else begin errors++; $error("FAIL stall_in_ready: got %b expected 0", in_ready); end
      end
      prev_stall = out_valid && !out_ready && !flush;
      hold_r = out_r; hold_tag = out_tag; hold_ill = out_illegal;
      if (out_valid && out_ready && !flush) begin
        checks++;
        assert (q_main.size() != 0)
        else begin errors++; $error("FAIL main_spurious: got tag %0d expected no result", out_tag); end
        if (q_main.size() != 0) begin
          e = q_main.pop_front();
          checks++;
          assert (out_r === e.r[31:0] && out_tag === e.tag && out_illegal === e.ill)
          else begin
            errors++;
            $error("FAIL main_result: got r=%h tag=%0d ill=%b expected r=%h tag=%0d ill=%b",
                   out_r, out_tag, out_illegal, e.r[31:0], e.tag, e.ill);
          end
          if (chk_lat) begin
            checks++;
            assert (pcyc - e.stamp == 3)
            else begin errors++; $error("FAIL main_latency: got %0d expected 3", pcyc - e.stamp); end
          end
        end
      end

      if (s8_valid && s8_ready) begin
        e.r = pend8_r; e.tag = s8_tag; e.ill = pend8_ill; e.stamp = pcyc;
        q8.push_back(e);
      end
      if (s8_ovalid) begin
        checks++;
        assert (q8.size() != 0)
        else begin errors++; $error("FAIL w8_spurious: got tag %0d expected no result", s8_otag); end
        if (q8.size() != 0) begin
          e = q8.pop_front();
          checks++;
          assert (s8_r === e.r[7:0] && s8_otag === e.tag && s8_oill === e.ill && pcyc - e.stamp == 3)
          else begin
            errors++;
            $error("FAIL w8_result: got r=%h tag=%0d ill=%b lat=%0d expected r=%h tag=%0d ill=%b lat=3",
                   s8_r, s8_otag, s8_oill, pcyc - e.stamp, e.r[7:0], e.tag, e.ill);
          end
        end
      end

      if (s64_valid && s64_ready) begin
        e.r = pend64_r; e.tag = s64_tag; e.ill = pend64_ill; e.stamp = pcyc;
        q64.push_back(e);
      end
      if (s64_ovalid) begin
        checks++;
        assert (q64.size() != 0)
        else begin errors++; $error("FAIL w64_spurious: got tag %0d expected no result", s64_otag); end
        if (q64.size() != 0) begin
          e = q64.pop_front();
          checks++;
          assert (s64_r === e.r && s64_otag === e.tag && s64_oill === e.ill && pcyc - e.stamp == 1)
          else begin
            errors++;
            $error("FAIL w64_result: got r=%h tag=%0d ill=%b lat=%0d expected r=%h tag=%0d ill=%b lat=1",
                   s64_r, s64_otag, s64_oill, pcyc - e.stamp, e.r, e.tag, e.ill);
          end
        end
      end
    end
  endtask

  // One clock: sample mid-cycle, then update drives just after the edge
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (bp_en) begin
      out_ready = (bp_i % 3 == 0);
      bp_i++;
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] sh, input logic [2:0] op,
                       input logic [4:0] tag, input logic [31:0] er, input logic eill,
                       input logic push);
    int k;
    in_valid = 1'b1; in_a = a; in_shamt = sh; in_op = op; in_tag = tag;
    pend_r = {32'd0, er}; pend_ill = eill; pend_push = push;
    last_acc = 1'b0;
    k = 0;
    while (!last_acc && k < 20) begin
      step();
      k++;
    end
    checks++;
    assert (last_acc)
    else begin errors++; $error("FAIL issue_timeout: tag %0d accepted=%b expected 1", tag, last_acc); end
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [4:0] sh,
                             input logic [2:0] op, input logic [4:0] tag);
    logic [63:0] r;
    logic        ill;
    r = ref_model(32, {32'd0, a}, int'(sh), op, ill);
    issue(a, sh, op, tag, r[31:0], ill, 1'b1);
  endtask

  initial begin
    logic [63:0] r;
    logic        ill;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; sw_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    s8_valid = 1'b0; s8_a = '0; s8_shamt = '0; s8_op = '0; s8_tag = '0;
    s64_valid = 1'b0; s64_a = '0; s64_shamt = '0; s64_op = '0; s64_tag = '0;
    pend_r = '0; pend8_r = '0; pend64_r = '0;
    pend_ill = 1'b0; pend8_ill = 1'b0; pend64_ill = 1'b0; pend_push = 1'b0;
    chk_lat = 1'b0; last_acc = 1'b0; bp_en = 1'b0; bp_i = 0;
    prev_stall = 1'b0; hold_r = '0; hold_tag = '0; hold_ill = 1'b0;

    // Reset and hold
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; assert (out_valid === 1'b0)
      else begin errors++; $error("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; assert (out_r === 32'd0)
      else begin errors++; $error("FAIL rst_out_r: got %h expected 0", out_r); end
    checks++; assert (out_tag === 5'd0 && out_illegal === 1'b0)
      else begin errors++; $error("FAIL rst_tag_ill: got %0d/%b expected 0/0", out_tag, out_illegal); end
    checks++; assert (in_ready === 1'b1)
      else begin errors++; $error("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; assert (s8_ovalid === 1'b0 && s64_ovalid === 1'b0)
      else begin errors++; $error("FAIL rst_sweep_valid: got %b/%b expected 0/0", s8_ovalid, s64_ovalid); end
    @(posedge clk); #1;

    // Basic ops, back to back, latency checked
    chk_lat = 1'b1;
    issue(32'h8000_00F1, 5'd4, 3'b000, 5'd1, 32'h0000_0F10, 1'b0, 1'b1);
    issue(32'h8000_00F1, 5'd4, 3'b001, 5'd2, 32'h0800_000F, 1'b0, 1'b1);
    issue(32'h8000_00F1, 5'd4, 3'b010, 5'd3, 32'hF800_000F, 1'b0, 1'b1);
    issue(32'h8000_00F1, 5'd4, 3'b011, 5'd4, 32'h0000_0F18, 1'b0, 1'b1);
    issue(32'h8000_00F1, 5'd4, 3'b100, 5'd5, 32'h1800_000F, 1'b0, 1'b1);
    // Edges
    issue(32'hDEAD_BEEF, 5'd0,  3'b010, 5'd6, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(32'h8000_0000, 5'd31, 3'b010, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(32'h1234_5678, 5'd9,  3'b110, 5'd8, 32'h1234_5678, 1'b1, 1'b1);
    issue(32'h8000_0001, 5'd31, 3'b100, 5'd9, 32'h0000_0003, 1'b0, 1'b1);
    drain(6);
    chk_lat = 1'b0;

    // Backpressure
    bp_i = 0; bp_en = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      issue_model($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 5'(t));
    end
    drain(30);
    bp_en = 1'b0;
    step();

    // Flush while tag 1 is presented
    issue(32'h0000_00FF, 5'd1, 3'b000, 5'd1, 32'h0, 1'b0, 1'b0);
    issue(32'h0000_00FF, 5'd2, 3'b000, 5'd2, 32'h0, 1'b0, 1'b0);
    issue(32'h0000_00FF, 5'd3, 3'b000, 5'd3, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checks++; assert (out_valid === 1'b1 && out_tag === 5'd1)
      else begin errors++; $error("FAIL flush_present: got v=%b tag=%0d expected v=1 tag=1", out_valid, out_tag); end
    checks++; assert (in_ready === 1'b0)
      else begin errors++; $error("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; assert (out_valid === 1'b0)
      else begin errors++; $error("FAIL flush_squash: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    chk_lat = 1'b1;
    issue_model(32'hA5A5_0F0F, 5'd8, 3'b011, 5'd4);
    drain(6);
    chk_lat = 1'b0;

    // Parameter sweep, one random op per cycle on both extra configurations
    for (int n = 0; n < 30; n++) begin
      s8_valid = 1'b1; s8_a = 8'($urandom); s8_shamt = 3'($urandom_range(0, 7));
      s8_op = 3'($urandom_range(0, 7)); s8_tag = 5'(n);
      r = ref_model(8, {56'd0, s8_a}, int'(s8_shamt), s8_op, ill);
      pend8_r = r; pend8_ill = ill;
      s64_valid = 1'b1; s64_a = {$urandom, $urandom}; s64_shamt = 6'($urandom_range(0, 63));
      s64_op = 3'($urandom_range(0, 7)); s64_tag = 5'(n);
      r = ref_model(64, s64_a, int'(s64_shamt), s64_op, ill);
      pend64_r = r; pend64_ill = ill;
      step();
    end
    s8_valid = 1'b0; s64_valid = 1'b0;
    drain(8);

    checks++; assert (q_main.size() == 0 && q8.size() == 0 && q64.size() == 0)
      else begin
        errors++;
        $error("FAIL drain: got %0d/%0d/%0d outstanding expected 0/0/0", q_main.size(), q8.size(), q64.size());
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
